// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter for the register file: ALU writes (port A) take
// priority over buffered long-latency results (port B), with a RAW pending mask.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic [AW-1:0]            a_reg,
  input  logic [DW-1:0]            a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [AW-1:0]            b_reg,
  input  logic [DW-1:0]            b_data,
  output logic                     RegWrite,
  output logic [AW-1:0]            WriteReg,
  output logic [DW-1:0]            WriteData,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     protocol_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] mem_reg  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          out_is_b;

  logic          a_sel, b_fire, b_live, fifo_empty, pop, push, bypass;
  logic [CW-1:0] count_nxt;
  logic          reg_write_nxt, out_is_b_nxt, err_nxt;
  logic [AW-1:0] write_reg_nxt;
  logic [DW-1:0] write_data_nxt;

  assign b_ready    = (count < CW'(DEPTH));
  assign fifo_count = count;

  // Arbitration: A first, then FIFO head, then a same-cycle B bypass.
  always_comb begin
    a_sel      = a_valid && (a_reg != '0);
    b_fire     = b_valid && b_ready;
    b_live     = b_fire && (b_reg != '0);
    fifo_empty = (count == '0);
    pop        = !a_sel && !fifo_empty;
    bypass     = !a_sel && fifo_empty && b_live;
    push       = b_live && !bypass;
  end

  // Destination mask of every live FIFO entry plus a B write sitting in the output stage.
  always_comb begin
    logic [PW-1:0] offset;
    pending_mask = '0;
    offset       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if (CW'(offset) < count) begin
        pending_mask = pending_mask | (32'(1) << mem_reg[i]);
      end
    end
    if (RegWrite && out_is_b) begin
      pending_mask = pending_mask | (32'(1) << WriteReg);
    end
  end

  // Next-state for occupancy, output stage and the sticky race flag.
  always_comb begin
    count_nxt      = count + CW'(push) - CW'(pop);
    reg_write_nxt  = 1'b0;
    out_is_b_nxt   = 1'b0;
    write_reg_nxt  = WriteReg;
    write_data_nxt = WriteData;
    err_nxt        = protocol_err || (a_sel && (|(pending_mask & (32'(1) << a_reg))));
    if (a_sel) begin
      reg_write_nxt  = 1'b1;
      write_reg_nxt  = a_reg;
      write_data_nxt = a_data;
    end else if (pop) begin
      reg_write_nxt  = 1'b1;
      out_is_b_nxt   = 1'b1;
      write_reg_nxt  = mem_reg[rd_ptr];
      write_data_nxt = mem_data[rd_ptr];
    end else if (bypass) begin
      reg_write_nxt  = 1'b1;
      out_is_b_nxt   = 1'b1;
      write_reg_nxt  = b_reg;
      write_data_nxt = b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      RegWrite     <= 1'b0;
      WriteReg     <= '0;
      WriteData    <= '0;
      out_is_b     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      count        <= count_nxt;
      RegWrite     <= reg_write_nxt;
      WriteReg     <= write_reg_nxt;
      WriteData    <= write_data_nxt;
      out_is_b     <= out_is_b_nxt;
      protocol_err <= err_nxt;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Payload storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= b_reg;
      mem_data[wr_ptr] <= b_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random
// traffic compared against a queue-based transaction model.
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, b_ready;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [31:0]   pending_mask;
  logic [2:0]    fifo_count;
  logic          protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .pending_mask(pending_mask), .fifo_count(fifo_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic        m_we, m_b, m_err;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].r] = 1'b1;
    if (m_we && m_b) m[m_reg] = 1'b1;
    return m;
  endfunction

  function automatic logic m_ready();
    return q.size() < DEPTH;
  endfunction

  task automatic model_clear();
    q.delete();
    m_we = 0; m_b = 0; m_err = 0; m_reg = '0; m_data = '0;
  endtask

  // Transaction-level rules applied to pre-edge model state.
  task automatic model_step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                            input logic bv, input logic [4:0] br, input logic [31:0] bd);
    logic        asel, live;
    logic [31:0] pm;
    ent_t        e;
    pm   = m_mask();
    asel = av && (ar != 0);
    live = bv && m_ready() && (br != 0);
    if (asel && pm[ar]) m_err = 1'b1;
    if (asel) begin
      m_we = 1; m_b = 0; m_reg = ar; m_data = ad;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1; m_b = 1; m_reg = e.r; m_data = e.d;
    end else if (live) begin
      m_we = 1; m_b = 1; m_reg = br; m_data = bd;
      live = 0;
    end else begin
      m_we = 0; m_b = 0;
    end
    if (live) begin
      e.r = br; e.d = bd;
      q.push_back(e);
    end
  endtask

  task automatic compare_all();
    check("RegWrite", 64'(RegWrite), 64'(m_we));
    if (m_we) begin
      check("WriteReg", 64'(WriteReg), 64'(m_reg));
      check("WriteData", 64'(WriteData), 64'(m_data));
    end
    check("pending_mask", 64'(pending_mask), 64'(m_mask()));
    check("fifo_count", 64'(fifo_count), 64'(q.size()));
    check("b_ready", 64'(b_ready), 64'(m_ready()));
    check("protocol_err", 64'(protocol_err), 64'(m_err));
  endtask

  // One clock: drive at the falling edge, step the model, compare at the next falling edge.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    model_step(av, ar, ad, bv, br, bd);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_RegWrite", 64'(RegWrite), 64'(0));
    check("rst_WriteReg", 64'(WriteReg), 64'(0));
    check("rst_WriteData", 64'(WriteData), 64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_pending", 64'(pending_mask), 64'(0));
    check("rst_err", 64'(protocol_err), 64'(0));
    model_clear();
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_b_ready", 64'(b_ready), 64'(1));
  endtask

  initial begin
    logic       av, bv;
    logic [4:0] ar, br;
    logic [31:0] ad, bd;
    int         a_pct;

    rst_n = 1'b0;
    a_valid = 0; a_reg = '0; a_data = '0;
    b_valid = 0; b_reg = '0; b_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // ALU write latency and register-0 drop
    cycle(1, 5, 32'h1234, 0, 0, 0);
    check("a_we", 64'(RegWrite), 64'(1));
    check("a_reg", 64'(WriteReg), 64'(5));
    check("a_data", 64'(WriteData), 64'h1234);
    cycle(1, 0, 32'h5555, 0, 0, 0);
    check("a_reg0_we", 64'(RegWrite), 64'(0));

    // Empty-FIFO bypass
    cycle(0, 0, 0, 1, 7, 32'hDEAD);
    check("byp_we", 64'(RegWrite), 64'(1));
    check("byp_reg", 64'(WriteReg), 64'(7));
    check("byp_mask", 64'(pending_mask), 64'h80);
    check("byp_count", 64'(fifo_count), 64'(0));
    idle();
    check("byp_mask_clr", 64'(pending_mask), 64'(0));

    // Fill under A pressure, stall, then drain in order
    for (int i = 1; i <= 4; i++) cycle(1, 20, 32'(i), 1, 5'(i), 32'h100 + 32'(i));
    check("full_count", 64'(fifo_count), 64'(4));
    check("full_ready", 64'(b_ready), 64'(0));
    check("full_mask", 64'(pending_mask), 64'h1E);
    cycle(1, 20, 5, 1, 9, 32'h109);
    cycle(1, 20, 6, 1, 9, 32'h109);
    cycle(0, 0, 0, 1, 9, 32'h109);
    check("drain1", 64'(WriteReg), 64'(1));
    cycle(0, 0, 0, 1, 9, 32'h109);
    check("drain2", 64'(WriteReg), 64'(2));
    idle(); check("drain3", 64'(WriteReg), 64'(3));
    idle(); check("drain4", 64'(WriteReg), 64'(4));
    idle(); check("drain9", 64'(WriteReg), 64'(9));
    check("drain9_data", 64'(WriteData), 64'h109);
    idle();
    check("drain_mask", 64'(pending_mask), 64'(0));

    // Duplicate destination keeps its mask bit until the last write
    cycle(1, 21, 0, 1, 3, 32'h31);
    cycle(1, 21, 0, 1, 3, 32'h32);
    idle(); check("dup_mask_a", 64'(pending_mask[3]), 64'(1));
    idle(); check("dup_mask_b", 64'(pending_mask[3]), 64'(1));
    check("dup_data", 64'(WriteData), 64'h32);
    idle(); check("dup_mask_c", 64'(pending_mask[3]), 64'(0));

    // ALU write racing a queued write
    cycle(1, 22, 0, 1, 8, 32'hB8);
    cycle(1, 8, 32'hA8, 0, 0, 0);
    check("race_err", 64'(protocol_err), 64'(1));
    check("race_a", 64'(WriteData), 64'hA8);
    idle();
    check("race_b_reg", 64'(WriteReg), 64'(8));
    check("race_b", 64'(WriteData), 64'hB8);
    idle(); check("race_sticky", 64'(protocol_err), 64'(1));

    // Reset with entries queued
    for (int i = 0; i < 3; i++) cycle(1, 23, 0, 1, 5'(10 + i), 32'(i));
    check("pre_rst_count", 64'(fifo_count), 64'(3));
    mid_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post_rst_we", 64'(RegWrite), 64'(0));
    end

    // Random traffic with varying ALU pressure and occasional resets
    a_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) a_pct = $urandom_range(0, 100);
      if (i % 900 == 899) mid_reset();
      av = ($urandom_range(0, 99) < a_pct);
      ar = 5'($urandom_range(0, 31));
      ad = $urandom;
      if (b_valid && !m_ready()) begin
        bv = 1'b1; br = b_reg; bd = b_data;
      end else begin
        bv = ($urandom_range(0, 2) != 0);
        br = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bd = $urandom;
      end
      cycle(av, ar, ad, bv, br, bd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
